uart_rx_display_ctrl: RTL
=========================

// Module: uart_rx_display_ctrl
// PURPOSE
//   Sequences reads from the uart_rx receive FIFO onto the board display.
//   Debounces the "next" push-button and issues one-cycle FIFO read strobes.
//   Captures each popped byte into a held display register.
//   Optional auto-scroll mode drains one byte per period. Latches sticky overflow/error flags for LEDs.
// PARAMETERS
//   P_UART_WIDTH       8          byte width, equals uart_rx P_UART_WIDTH
//   P_DEBOUNCE_CYCLES  50000      stable cycles before button change accepted (10 ms @ 5 MHz)
//   P_DEBOUNCE_BITS    16         width of debounce counter
//   P_AUTO_PERIOD      5000000    cycles between auto-scroll reads (1 s @ 5 MHz)
//   P_AUTO_BITS        23         width of auto-scroll timer
// PORTS
//   CLK            in   1             system clock (5 MHz)
//   reset          in   1             synchronous, active-high reset
//   btn_next       in   1             raw asynchronous push-button, active-high
//   auto_mode      in   1             1 = auto-scroll enabled
//   clear_flags    in   1             one-cycle clear of sticky flags
//   fifo_empty     in   1             uart_rx fifo_empty
//   fifo_full      in   1             uart_rx fifo_full
//   rx_error       in   1             uart_rx error
//   fifo_dout      in   P_UART_WIDTH  {data_out_msd, data_out_lsd}
//   rd_en          out  1             to uart_rx display_next; one-cycle pulse
//   disp_byte      out  P_UART_WIDTH  byte currently shown
//   disp_valid     out  1             disp_byte holds a received byte
//   rd_count       out  8             bytes popped, wraps 255->0
//   overflow_flag  out  1             sticky: FIFO was full
//   error_flag     out  1             sticky: receiver reported error
// BEHAVIOUR
//   Reset: all outputs 0; FSM=S_IDLE; debounce/auto counters 0; synchronizer and stable button state 0.
//   Button path: 2-FF synchronizer -> debounce.
//     Counter increments while sync != stable, clears when equal.
//     At P_DEBOUNCE_CYCLES-1, stable <= sync and counter clears.
//     Rising edge of stable = btn_req, one cycle.
//   Auto timer: held at 0 when auto_mode=0 or FSM!=S_IDLE; else increments.
//     At P_AUTO_PERIOD-1: auto_req=1 for one cycle, timer -> 0.
//   FSM (fifo_dout is valid the cycle after rd_en; FIFO is not first-word-fall-through):
//     S_IDLE:  (btn_req|auto_req) & !fifo_empty -> S_READ. Request with fifo_empty=1 is dropped, not queued.
//     S_READ:  rd_en=1 this cycle only -> S_CAPT
//     S_CAPT:  disp_byte<=fifo_dout; disp_valid<=1; rd_count<=rd_count+1 -> S_IDLE
//   Latency: btn_req/auto_req cycle N -> rd_en at N+1 -> disp_byte updated at N+3.
//   Requests arriving in S_READ/S_CAPT are dropped. Max one pop per request.
//   btn_req and auto_req in the same cycle -> single read.
//   Sticky flags: set in any cycle where fifo_full=1 (overflow_flag) or rx_error=1 (error_flag).
//     clear_flags clears both; set wins over clear in the same cycle.
//   disp_byte/disp_valid unaffected by clear_flags; only reset clears them.
//   Reset mid-operation (S_READ/S_CAPT): return to S_IDLE, rd_en=0 next cycle, no capture.
//   Switching auto_mode 1->0 mid-count: timer zeroes next cycle, no read issued.
// TESTING
//   1. Reset, fifo_empty=0, fifo_dout=8'hA5; press btn_next 60000 cycles
//      -> exactly one rd_en pulse; disp_byte=A5; disp_valid=1; rd_count=1.
//   2. Glitch: btn_next high 1000 cycles, then low -> no rd_en; stable stays 0.
//   3. fifo_empty=1, press button -> no rd_en; disp_valid stays 0.
//      Release, deassert empty -> still no rd_en.
//   4. auto_mode=1, fifo_empty=0, dout increments per pop, P_AUTO_PERIOD=100 (sim override)
//      -> rd_en every 103 cycles; disp_byte sequence 00,01,02.
//   5. rx_error pulse 1 cycle -> error_flag=1.
//      clear_flags with rx_error=1 same cycle -> flag stays 1; later clear_flags alone -> 0.
//      fifo_full=1 -> overflow_flag=1.
//   6. Assert reset in cycle after rd_en -> disp_byte=0, disp_valid=0, rd_count=0, state S_IDLE.
//      256 pops -> rd_count wraps to 0.

Source files
------------

// File: rtl/uart_rx_display_ctrl.sv
// Display sequencer for the uart_rx receive FIFO.
// A debounced "next" button or an auto-scroll timer issues one read
// strobe to the FIFO. The popped byte is held for display. Overflow and
// receiver-error conditions are latched as sticky LED flags.
module uart_rx_display_ctrl #(
  parameter int unsigned P_UART_WIDTH      = 8,
  parameter int unsigned P_DEBOUNCE_CYCLES = 50000,
  parameter int unsigned P_DEBOUNCE_BITS   = 16,
  parameter int unsigned P_AUTO_PERIOD     = 5000000,
  parameter int unsigned P_AUTO_BITS       = 23
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic                    btn_next,
  input  logic                    auto_mode,
  input  logic                    clear_flags,
  input  logic                    fifo_empty,
  input  logic                    fifo_full,
  input  logic                    rx_error,
  input  logic [P_UART_WIDTH-1:0] fifo_dout,
  output logic                    rd_en,
  output logic [P_UART_WIDTH-1:0] disp_byte,
  output logic                    disp_valid,
  output logic [7:0]              rd_count,
  output logic                    overflow_flag,
  output logic                    error_flag
);

  localparam logic [P_DEBOUNCE_BITS-1:0] DB_LAST   = P_DEBOUNCE_BITS'(P_DEBOUNCE_CYCLES - 1);
  localparam logic [P_AUTO_BITS-1:0]     AUTO_LAST = P_AUTO_BITS'(P_AUTO_PERIOD - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_CAPT} state_t;

  state_t                    state_q, state_d;
  logic                      sync1_q, sync2_q;
  logic                      stable_q, stable_d, stable_prev_q;
  logic [P_DEBOUNCE_BITS-1:0] db_cnt_q, db_cnt_d;
  logic [P_AUTO_BITS-1:0]    auto_cnt_q, auto_cnt_d;
  logic                      auto_req_q, auto_req_d;
  logic [P_UART_WIDTH-1:0]   disp_q, disp_d;
  logic                      valid_q, valid_d;
  logic [7:0]                cnt_q, cnt_d;
  logic                      ovf_q, ovf_d;
  logic                      err_q, err_d;
  logic                      btn_req;
  logic                      auto_req;

  // One-cycle request on the rising edge of the debounced button.
  assign btn_req  = stable_q & ~stable_prev_q;
  // Registered timer pulse; a mode switch-off in that cycle still suppresses it.
  assign auto_req = auto_req_q & auto_mode;

  // Debounce: accept a new level only after it has differed for the full window.
  always_comb begin
    stable_d = stable_q;
    db_cnt_d = '0;
    if (sync2_q != stable_q) begin
      if (db_cnt_q == DB_LAST) begin
        stable_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + P_DEBOUNCE_BITS'(1);
      end
    end
  end

  // Auto-scroll timer runs only while idle with auto mode on.
  always_comb begin
    auto_cnt_d = '0;
    auto_req_d = 1'b0;
    if (auto_mode && state_q == S_IDLE) begin
      if (auto_cnt_q == AUTO_LAST) begin
        auto_req_d = 1'b1;
      end else begin
        auto_cnt_d = auto_cnt_q + P_AUTO_BITS'(1);
      end
    end
  end

  // Read sequencer: strobe the FIFO, then capture its output one cycle later.
  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    disp_d  = disp_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if ((btn_req || auto_req) && !fifo_empty) state_d = S_READ;
      S_READ: begin
        rd_en   = 1'b1;
        state_d = S_CAPT;
      end
      S_CAPT: begin
        disp_d  = fifo_dout;
        valid_d = 1'b1;
        cnt_d   = cnt_q + 8'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sticky flags: a set condition beats a simultaneous clear.
  always_comb begin
    ovf_d = fifo_full | (ovf_q & ~clear_flags);
    err_d = rx_error  | (err_q & ~clear_flags);
  end

  // State and datapath registers.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q       <= S_IDLE;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      db_cnt_q      <= '0;
      auto_cnt_q    <= '0;
      auto_req_q    <= 1'b0;
      disp_q        <= '0;
      valid_q       <= 1'b0;
      cnt_q         <= '0;
      ovf_q         <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= btn_next;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      db_cnt_q      <= db_cnt_d;
      auto_cnt_q    <= auto_cnt_d;
      auto_req_q    <= auto_req_d;
      disp_q        <= disp_d;
      valid_q       <= valid_d;
      cnt_q         <= cnt_d;
      ovf_q         <= ovf_d;
      err_q         <= err_d;
    end
  end

  assign disp_byte     = disp_q;
  assign disp_valid    = valid_q;
  assign rd_count      = cnt_q;
  assign overflow_flag = ovf_q;
  assign error_flag    = err_q;

endmodule
